// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4 -- receive end of a 4-slot time-division-multiplexed serial link.
//
// A frame is four slots (0,1,2,3) of W bits each, sent MSB first. The block
// hunts for the frame marker (sync together with slot 0 MSB), then
// deserialises each slot into its own channel register and pulses
// word_valid (and frame_valid for slot 3) one cycle after the last bit.
//
// Parameter
//   W            channel word width, legal 2..16 (default 8)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           bit enable; one serial bit is taken per edge with en=1
//   din          serial data, MSB of each word first
//   sync         frame marker, high with the MSB of slot 0
//   a, b, c, d   channel 0..3 words, each held until its own slot rewrites it
//   s            slot index of the most recently delivered word
//   word_valid   one-cycle pulse when a word lands in a/b/c/d
//   frame_valid  one-cycle pulse when the slot-3 word lands
//   locked       high while the receiver is locked to the frame
//   sync_err     one-cycle pulse on a framing error (framing checks only)
//
// Build option
//   TDM_DEMUX4_SYNC_CHECK_EN  when defined, sync is checked on every locked
//                             bit: a misplaced sync restarts the frame at the
//                             current bit, a missing sync drops back to HUNT.
//                             When undefined, sync is ignored once locked and
//                             sync_err is tied to 0.
// -----------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         din,
    input  logic         sync,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic [1:0]   s,
    output logic         word_valid,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    localparam int            CW       = $clog2(W);
    // The last bit of a word is combined straight from din, so only the
    // first W-1 bits of a word ever need to be stored.
    localparam int            SW       = W - 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(W - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q,   state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [1:0]    slot_q,    slot_d;
    logic [SW-1:0] shift_q,   shift_d;
    logic [1:0]    s_q,       s_d;
    logic          wv_q,      wv_d;
    logic          fv_q,      fv_d;

    logic [W-1:0]  word_w;     // word formed by the stored bits plus din
    logic [3:0]    load_en;    // one-hot channel write strobe
    logic          advance;    // take din as the next bit of the current slot

    logic [W-1:0]  ch_all [4];

    assign word_w = {shift_q, din};

`ifdef TDM_DEMUX4_SYNC_CHECK_EN
    logic err_q, err_d;
    logic frame_start;

    // Position where a new frame (and hence sync) is expected.
    assign frame_start = (slot_q == 2'd0) && (bit_cnt_q == '0);
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        slot_d    = slot_q;
        shift_d   = shift_q;
        s_d       = s_q;
        wv_d      = 1'b0;
        fv_d      = 1'b0;
        load_en   = '0;
        advance   = 1'b0;
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        err_d     = 1'b0;
`endif

        if (en) begin
            case (state_q)
                HUNT: begin
                    // Bits before the first sync are discarded.
                    if (sync) begin
                        state_d   = LOCKED;
                        shift_d   = SW'(din);
                        bit_cnt_d = CW'(1);
                        slot_d    = 2'd0;
                    end
                end
                LOCKED: begin
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
                    if (sync && !frame_start) begin
                        // Misplaced marker: realign so this bit is the
                        // MSB of slot 0; the partial word is dropped.
                        err_d     = 1'b1;
                        shift_d   = SW'(din);
                        bit_cnt_d = CW'(1);
                        slot_d    = 2'd0;
                    end else if (!sync && frame_start) begin
                        // Expected marker missing: alignment lost.
                        err_d     = 1'b1;
                        state_d   = HUNT;
                        bit_cnt_d = '0;
                        slot_d    = 2'd0;
                    end else begin
                        advance   = 1'b1;
                    end
`else
                    advance = 1'b1;
`endif
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        if (advance) begin
            shift_d = word_w[SW-1:0];
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d        = '0;
                load_en[slot_q]  = 1'b1;
                s_d              = slot_q;
                wv_d             = 1'b1;
                fv_d             = (slot_q == 2'd3);
                slot_d           = slot_q + 2'd1;   // wraps 3 -> 0
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            slot_q    <= 2'd0;
            shift_q   <= '0;
            s_q       <= 2'd0;
            wv_q      <= 1'b0;
            fv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            slot_q    <= slot_d;
            shift_q   <= shift_d;
            s_q       <= s_d;
            wv_q      <= wv_d;
            fv_q      <= fv_d;
        end
    end

`ifdef TDM_DEMUX4_SYNC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sync_err = err_q;
`else
    assign sync_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Channel registers: each is written only by its own slot.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [W-1:0] ch_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ch_q <= '0;
            end else if (load_en[gi]) begin
                ch_q <= word_w;
            end
        end

        assign ch_all[gi] = ch_q;
    end

    assign a           = ch_all[0];
    assign b           = ch_all[1];
    assign c           = ch_all[2];
    assign d           = ch_all[3];
    assign s           = s_q;
    assign word_valid  = wv_q;
    assign frame_valid = fv_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// Testbench for tdm_demux4 (W = 8). Directed serial frames are driven on the
// falling edge; each delivered word's expected slot/value is queued when its
// last bit is driven, and a monitor process pops and checks every word_valid
// pulse against the queue and a bench-side copy of the four channels.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n, en, din, sync;
    logic [7:0] a, b, c, d;
    logic [1:0] s;
    logic       word_valid, frame_valid, locked, sync_err;

    tdm_demux4 #(.W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .din         (din),
        .sync        (sync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .s           (s),
        .word_valid  (word_valid),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] slot;
        logic [7:0] word;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_ch [4];
    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         wv_cnt = 0;
    int         fv_cnt = 0;
    int         err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: samples outputs on the falling edge.
    task automatic monitor();
        logic en_s;
        exp_t e;
        forever begin
            @(posedge clk);
            en_s = en;
            @(negedge clk);
            if (sync_err) err_cnt++;
            if (frame_valid && !word_valid) check("fv_without_wv", {31'd0, frame_valid}, 32'd0);
            if (word_valid) begin
                wv_cnt++;
                if (frame_valid) fv_cnt++;
                check("wv_while_en0", {31'd0, en_s}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    exp_ch[e.slot] = e.word;
                    $display("word: slot=%0d data=%02h (dut s=%0d a=%02h b=%02h c=%02h d=%02h fv=%0b)",
                             e.slot, e.word, s, a, b, c, d, frame_valid);
                    check("slot_s", {30'd0, s}, {30'd0, e.slot});
                    check("frame_valid", {31'd0, frame_valid}, {31'd0, (e.slot == 2'd3)});
                    check("ch_a", {24'd0, a}, {24'd0, exp_ch[0]});
                    check("ch_b", {24'd0, b}, {24'd0, exp_ch[1]});
                    check("ch_c", {24'd0, c}, {24'd0, exp_ch[2]});
                    check("ch_d", {24'd0, d}, {24'd0, exp_ch[3]});
                end
            end
        end
    endtask

    task automatic send_bit(input logic bit_v, input logic sync_v, input logic en_v);
        @(negedge clk);
        din  = bit_v;
        sync = sync_v;
        en   = en_v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    endtask

    // Sends one word MSB first; sync on bit 0 if sync_first, and also on bit
    // sync_idx (if 0..7). With gaps, an en=0 cycle with random din/sync follows
    // every bit.
    task automatic send_word(input logic [7:0] w, input logic [1:0] slot,
                             input bit sync_first, input bit gaps, input int sync_idx);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                e.slot = slot;
                e.word = w;
                exp_q.push_back(e);
            end
            send_bit(w[7-i], (i == 0 && sync_first) || (i == sync_idx), 1'b1);
            if (gaps) send_bit(1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3, input bit gaps);
        send_word(w0, 2'd0, 1'b1, gaps, -1);
        send_word(w1, 2'd1, 1'b0, gaps, -1);
        send_word(w2, 2'd2, 1'b0, gaps, -1);
        send_word(w3, 2'd3, 1'b0, gaps, -1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, {24'd0, a}, 32'd0);
        check({tag, "_b"}, {24'd0, b}, 32'd0);
        check({tag, "_c"}, {24'd0, c}, 32'd0);
        check({tag, "_d"}, {24'd0, d}, 32'd0);
        check({tag, "_s"}, {30'd0, s}, 32'd0);
        check({tag, "_wv"}, {31'd0, word_valid}, 32'd0);
        check({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_locked"}, {31'd0, locked}, 32'd0);
        check({tag, "_sync_err"}, {31'd0, sync_err}, 32'd0);
    endtask

    initial begin
        int  wv0, fv0, err0;
        logic [7:0] tmp;
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        sync  = 1'b0;
        for (int i = 0; i < 4; i++) exp_ch[i] = 8'h00;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Bits before the first sync are discarded
        for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1'b0, 1'b1);
        idle(2);
        check("pre_sync_locked", {31'd0, locked}, 32'd0);
        check("pre_sync_words", wv_cnt, 32'd0);
        check("pre_sync_a", {24'd0, a}, 32'd0);
        check("pre_sync_d", {24'd0, d}, 32'd0);

        // One frame, en continuously high
        wv0 = wv_cnt; fv0 = fv_cnt;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0);
        idle(2);
        check("frame1_words", wv_cnt - wv0, 32'd4);
        check("frame1_frames", fv_cnt - fv0, 32'd1);
        check("frame1_locked", {31'd0, locked}, 32'd1);

        // Same frame with en toggling
        wv0 = wv_cnt; fv0 = fv_cnt;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1);
        idle(2);
        check("gaps_words", wv_cnt - wv0, 32'd4);
        check("gaps_frames", fv_cnt - fv0, 32'd1);

        // Two back-to-back frames, the second rewriting every channel
        wv0 = wv_cnt; fv0 = fv_cnt;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0);
        send_frame(8'h5A, 8'h66, 8'h0F, 8'h80, 1'b0);
        idle(2);
        check("b2b_words", wv_cnt - wv0, 32'd8);
        check("b2b_frames", fv_cnt - fv0, 32'd2);
        check("b2b_a", {24'd0, a}, 32'h5A);

        // sync raised at slot 1 bit 3
        wv0 = wv_cnt; err0 = err_cnt;
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        send_word(8'h11, 2'd0, 1'b1, 1'b0, -1);
        tmp = 8'h3C;
        for (int i = 0; i < 3; i++) send_bit(tmp[7-i], 1'b0, 1'b1);
        send_frame(8'h77, 8'h88, 8'h99, 8'hAA, 1'b0);
        idle(2);
        check("misplaced_sync_err", err_cnt - err0, 32'd1);
        check("misplaced_sync_words", wv_cnt - wv0, 32'd5);
        check("misplaced_sync_a", {24'd0, a}, 32'h77);
`else
        tmp = 8'h3C;
        send_word(8'h11, 2'd0, 1'b1, 1'b0, -1);
        send_word(tmp,   2'd1, 1'b0, 1'b0, 3);
        send_word(8'h55, 2'd2, 1'b0, 1'b0, -1);
        send_word(8'hAA, 2'd3, 1'b0, 1'b0, -1);
        idle(2);
        check("ignored_sync_err", err_cnt - err0, 32'd0);
        check("ignored_sync_words", wv_cnt - wv0, 32'd4);
        check("ignored_sync_b", {24'd0, b}, 32'h3C);
`endif

        // Reset pulsed during slot 2
        send_word(8'h12, 2'd0, 1'b1, 1'b0, -1);
        send_word(8'h34, 2'd1, 1'b0, 1'b0, -1);
        tmp = 8'h56;
        for (int i = 0; i < 3; i++) send_bit(tmp[7-i], 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        for (int i = 0; i < 4; i++) exp_ch[i] = 8'h00;
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        wv0 = wv_cnt;
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0, 1'b1);
        idle(2);
        check("post_rst_locked", {31'd0, locked}, 32'd0);
        check("post_rst_words", wv_cnt - wv0, 32'd0);
        send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0);
        idle(2);
        check("relock_locked", {31'd0, locked}, 32'd1);
        check("relock_words", wv_cnt - wv0, 32'd4);
        check("relock_c", {24'd0, c}, 32'hBE);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
